// File: rtl/aha_sif_read_bridge_if.sv
// aha_sif_read_bridge_if: AXI4 read channels plus the CGRA SIF
// packet read port, bundled for the read bridge.
interface aha_sif_read_bridge_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] ARID;
    logic [31:0]         ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARLOCK;
    logic [3:0]          ARCACHE;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_WIDTH-1:0] RID;
    logic [63:0]         RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    logic [31:0]         SIF_RD_ADDR;
    logic                SIF_RD_EN;
    logic [63:0]         SIF_RD_DATA;
    logic                SIF_RD_VALID;

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        input  ARLOCK, ARCACHE, ARPROT, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        output SIF_RD_ADDR, SIF_RD_EN,
        input  SIF_RD_DATA, SIF_RD_VALID
    );

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        output ARLOCK, ARCACHE, ARPROT, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        input  SIF_RD_ADDR, SIF_RD_EN,
        output SIF_RD_DATA, SIF_RD_VALID
    );
endinterface

// File: rtl/aha_sif_read_bridge.sv
// aha_sif_read_bridge: AXI4 read slave turning 64-bit bursts into
// single-beat SIF packet reads, with a per-beat response timeout.
module aha_sif_read_bridge #(
    parameter int ID_WIDTH = 4,
    parameter int TIMEOUT  = 256
) (
    input logic                  ACLK,
    input logic                  ARESETn,
    aha_sif_read_bridge_if.slave bus
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_arready, w_arready_nxt;
    logic [ID_WIDTH-1:0] r_id, w_id_nxt;
    logic [31:0]         r_addr, w_addr_nxt;
    logic [7:0]          r_len, w_len_nxt;
    logic [2:0]          r_size, w_size_nxt;
    logic [1:0]          r_burst, w_burst_nxt;
    logic [7:0]          r_beat, w_beat_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic                r_err_all, w_err_all_nxt;
    logic [63:0]         r_rdata, w_rdata_nxt;
    logic [1:0]          r_rresp, w_rresp_nxt;

    logic [31:0] w_bound;
    logic [31:0] w_base;
    logic [31:0] w_incr;
    logic        w_wrap_ok;
    logic [31:0] w_addr_adv;
    logic        w_last;
    logic        w_timeout;
    logic        w_unused;

    assign w_unused = ^{bus.ARLOCK, bus.ARCACHE, bus.ARPROT};

    // WRAP only for legal lengths; everything else steps like INCR
    assign w_bound   = ({24'd0, r_len} + 32'd1) << r_size;
    assign w_base    = r_addr & ~(w_bound - 32'd1);
    assign w_incr    = r_addr + (32'd1 << r_size);
    assign w_wrap_ok = (r_burst == 2'b10) &&
                       (r_len == 8'd1 || r_len == 8'd3 ||
                        r_len == 8'd7 || r_len == 8'd15);

    always_comb begin
        w_addr_adv = w_incr;
        if (r_burst == 2'b00) begin
            w_addr_adv = r_addr;
        end else if (w_wrap_ok && (w_incr == w_base + w_bound)) begin
            w_addr_adv = w_base;
        end
    end

    assign w_last    = (r_beat == r_len);
    assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_id_nxt      = r_id;
        w_addr_nxt    = r_addr;
        w_len_nxt     = r_len;
        w_size_nxt    = r_size;
        w_burst_nxt   = r_burst;
        w_beat_nxt    = r_beat;
        w_timer_nxt   = r_timer;
        w_err_all_nxt = r_err_all;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        unique case (r_state)
            S_IDLE: begin
                if (bus.ARVALID && r_arready) begin
                    w_id_nxt    = bus.ARID;
                    w_addr_nxt  = bus.ARADDR;
                    w_len_nxt   = bus.ARLEN;
                    w_size_nxt  = bus.ARSIZE;
                    w_burst_nxt = bus.ARBURST;
                    w_beat_nxt  = 8'd0;
                    w_rdata_nxt = 64'd0;
                    if (bus.ARSIZE > 3'd3) begin
                        w_err_all_nxt = 1'b1;
                        w_rresp_nxt   = 2'b10;
                        w_state_nxt   = S_RESP;
                    end else begin
                        w_err_all_nxt = 1'b0;
                        w_rresp_nxt   = 2'b00;
                        w_state_nxt   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + 1'b1;
                // data arriving on the timeout cycle still wins
                if (bus.SIF_RD_VALID) begin
                    w_rdata_nxt = bus.SIF_RD_DATA;
                    w_rresp_nxt = 2'b00;
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_rdata_nxt = 64'd0;
                    w_rresp_nxt = 2'b10;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.RREADY) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_addr_nxt  = w_addr_adv;
                        w_beat_nxt  = r_beat + 8'd1;
                        w_state_nxt = r_err_all ? S_RESP : S_ISSUE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_arready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_id      <= '0;
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_size    <= 3'd0;
            r_burst   <= 2'd0;
            r_beat    <= 8'd0;
            r_timer   <= '0;
            r_err_all <= 1'b0;
            r_rdata   <= 64'd0;
            r_rresp   <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_arready_nxt;
            r_id      <= w_id_nxt;
            r_addr    <= w_addr_nxt;
            r_len     <= w_len_nxt;
            r_size    <= w_size_nxt;
            r_burst   <= w_burst_nxt;
            r_beat    <= w_beat_nxt;
            r_timer   <= w_timer_nxt;
            r_err_all <= w_err_all_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    assign bus.ARREADY     = r_arready;
    assign bus.RVALID      = (r_state == S_RESP);
    assign bus.RLAST       = (r_state == S_RESP) && w_last;
    assign bus.RID         = r_id;
    assign bus.RDATA       = r_rdata;
    assign bus.RRESP       = r_rresp;
    assign bus.SIF_RD_EN   = (r_state == S_ISSUE);
    assign bus.SIF_RD_ADDR = {r_addr[31:3], 3'b000};
endmodule

// File: tb/tb_aha_sif_read_bridge.sv
// tb_aha_sif_read_bridge: directed burst table, random bursts against
// an arithmetic address/response model, and reset corner cases.
module tb_aha_sif_read_bridge;
    localparam int TO = 8;

    typedef struct {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        int               delay;
        int               stall;
        logic [63:0]      data;
        int               en;
        logic             tab;
        logic [3:0][31:0] ea;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   en_count = 0;
    vec_t tab [14];

    aha_sif_read_bridge_if #(.ID_WIDTH(4)) bus ();

    aha_sif_read_bridge #(
        .ID_WIDTH(4),
        .TIMEOUT (TO)
    ) dut (
        .ACLK   (clk),
        .ARESETn(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.SIF_RD_EN) en_count <= en_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [3:0] id, input logic [31:0] addr,
        input int len, input int size, input int burst,
        input int dly, input int stall, input logic [63:0] data,
        input int en, input logic [31:0] a0, input logic [31:0] a1,
        input logic [31:0] a2, input logic [31:0] a3);
        vec_t v;
        v.id = id;
        v.addr = addr;
        v.len = 8'(len);
        v.size = 3'(size);
        v.burst = 2'(burst);
        v.delay = dly;
        v.stall = stall;
        v.data = data;
        v.en = en;
        v.tab = 1'b1;
        v.ea[0] = a0;
        v.ea[1] = a1;
        v.ea[2] = a2;
        v.ea[3] = a3;
        return v;
    endfunction

    // beat address from the burst rules: offset within a wrap window
    function automatic logic [31:0] model_addr(input vec_t v, input int b);
        longint bytes, bound, base, a;
        bytes = longint'(64'd1 << v.size);
        if (v.burst == 2'b00) return v.addr;
        if (v.burst == 2'b10 && (v.len == 8'd1 || v.len == 8'd3 ||
                                 v.len == 8'd7 || v.len == 8'd15)) begin
            bound = (longint'(v.len) + 1) * bytes;
            base  = longint'(v.addr) - (longint'(v.addr) % bound);
            a = base + ((longint'(v.addr) - base + b * bytes) % bound);
            return a[31:0];
        end
        a = longint'(v.addr) + b * bytes;
        return a[31:0];
    endfunction

    task automatic chk_reset(input string t);
        chk({t, "_arready"}, 64'(bus.ARREADY), 64'd0);
        chk({t, "_rvalid"}, 64'(bus.RVALID), 64'd0);
        chk({t, "_rlast"}, 64'(bus.RLAST), 64'd0);
        chk({t, "_rresp"}, 64'(bus.RRESP), 64'd0);
        chk({t, "_rid"}, 64'(bus.RID), 64'd0);
        chk({t, "_rdata"}, bus.RDATA, 64'd0);
        chk({t, "_sif_en"}, 64'(bus.SIF_RD_EN), 64'd0);
        chk({t, "_sif_addr"}, 64'(bus.SIF_RD_ADDR), 64'd0);
    endtask

    task automatic run_burst(input vec_t v);
        logic        err;
        int          en0;
        int          n;
        logic [63:0] d;
        logic [63:0] ed;
        logic [1:0]  er;
        logic [31:0] ea;
        err = (v.size > 3'd3);
        en0 = en_count;
        bus.ARID = v.id;
        bus.ARADDR = v.addr;
        bus.ARLEN = v.len;
        bus.ARSIZE = v.size;
        bus.ARBURST = v.burst;
        bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < 20) begin
            tick();
            n++;
        end
        chk("ar_ready", 64'(bus.ARREADY), 64'd1);
        tick();
        bus.ARVALID = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            d = v.data + 64'(b);
            ed = 64'd0;
            er = 2'b10;
            if (!err) begin
                ea = (v.tab && b < 4) ? v.ea[b] : model_addr(v, b);
                chk("sif_en", 64'(bus.SIF_RD_EN), 64'd1);
                chk("sif_addr", 64'(bus.SIF_RD_ADDR),
                    64'(ea & ~32'h7));
                if (v.delay <= TO) begin
                    repeat (v.delay) tick();
                    chk("rv_early", 64'(bus.RVALID), 64'd0);
                    bus.SIF_RD_VALID = 1'b1;
                    bus.SIF_RD_DATA = d;
                    tick();
                    bus.SIF_RD_VALID = 1'b0;
                    bus.SIF_RD_DATA = {$urandom, $urandom};
                    ed = d;
                    er = 2'b00;
                end else begin
                    repeat (TO) tick();
                    chk("rv_early", 64'(bus.RVALID), 64'd0);
                    tick();
                end
            end
            chk("rvalid", 64'(bus.RVALID), 64'd1);
            chk("rdata", bus.RDATA, ed);
            chk("rresp", 64'(bus.RRESP), 64'(er));
            chk("rlast", 64'(bus.RLAST), 64'(b == int'(v.len)));
            chk("rid", 64'(bus.RID), 64'(v.id));
            for (int s = 0; s < v.stall; s++) begin
                if (s == 0 && !err && v.delay > TO) begin
                    bus.SIF_RD_VALID = 1'b1;
                    bus.SIF_RD_DATA = {$urandom, $urandom};
                end
                tick();
                bus.SIF_RD_VALID = 1'b0;
                chk("hold_rvalid", 64'(bus.RVALID), 64'd1);
                chk("hold_rdata", bus.RDATA, ed);
                chk("hold_rresp", 64'(bus.RRESP), 64'(er));
                chk("hold_no_en", 64'(bus.SIF_RD_EN), 64'd0);
            end
            bus.RREADY = 1'b1;
            tick();
            bus.RREADY = 1'b0;
        end
        chk("end_rvalid", 64'(bus.RVALID), 64'd0);
        chk("end_arready", 64'(bus.ARREADY), 64'd1);
        chk("en_pulses", 64'(en_count - en0), 64'(v.en));
    endtask

    initial begin
        vec_t r;
        int   n;
        tab[0] = mk(4'h5, 32'h100, 0, 3, 1, 2, 0,
                    64'hDEADBEEF_CAFEF00D, 1,
                    32'h100, 0, 0, 0);
        tab[1] = mk(4'h1, 32'h0, 3, 3, 1, 1, 0,
                    64'h1111_0000_0000_0010, 4,
                    32'h0, 32'h8, 32'h10, 32'h18);
        tab[2] = mk(4'h2, 32'h18, 3, 3, 2, 1, 0,
                    64'h2222_0000_0000_0020, 4,
                    32'h18, 32'h0, 32'h8, 32'h10);
        tab[3] = mk(4'h3, 32'h40, 1, 3, 1, 2, 5,
                    64'h3333_0000_0000_0030, 2,
                    32'h40, 32'h48, 0, 0);
        tab[4] = mk(4'h4, 32'h200, 2, 3, 0, 3, 1,
                    64'h4444_0000_0000_0040, 3,
                    32'h200, 32'h200, 32'h200, 0);
        tab[5] = mk(4'h6, 32'hFFFF_FFF0, 3, 3, 1, 1, 0,
                    64'h5555_0000_0000_0050, 4,
                    32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0, 32'h8);
        tab[6] = mk(4'h7, 32'h104, 3, 2, 1, 1, 0,
                    64'h6666_0000_0000_0060, 4,
                    32'h104, 32'h108, 32'h10C, 32'h110);
        tab[7] = mk(4'h8, 32'h18, 2, 3, 2, 1, 0,
                    64'h7777_0000_0000_0070, 3,
                    32'h18, 32'h20, 32'h28, 0);
        tab[8] = mk(4'h9, 32'h30, 1, 3, 3, 1, 0,
                    64'h8888_0000_0000_0080, 2,
                    32'h30, 32'h38, 0, 0);
        tab[9] = mk(4'hA, 32'h14, 1, 2, 2, 1, 0,
                    64'h9999_0000_0000_0090, 2,
                    32'h14, 32'h10, 0, 0);
        tab[10] = mk(4'hB, 32'h0, 1, 4, 1, 1, 2,
                     64'hAAAA_0000_0000_00A0, 0,
                     0, 0, 0, 0);
        tab[11] = mk(4'hC, 32'h80, 0, 3, 1, TO, 0,
                     64'hBBBB_0000_0000_00B0, 1,
                     32'h80, 0, 0, 0);
        tab[12] = mk(4'hD, 32'h90, 1, 3, 1, TO + 1, 2,
                     64'hCCCC_0000_0000_00C0, 2,
                     32'h90, 32'h98, 0, 0);
        tab[13] = mk(4'hE, 32'hA0, 0, 3, 1, 1, 0,
                     64'hDDDD_0000_0000_00D0, 1,
                     32'hA0, 0, 0, 0);

        rst_n = 1'b0;
        bus.ARID = '0;
        bus.ARADDR = '0;
        bus.ARLEN = '0;
        bus.ARSIZE = '0;
        bus.ARBURST = '0;
        bus.ARLOCK = 1'b0;
        bus.ARCACHE = '0;
        bus.ARPROT = '0;
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        bus.SIF_RD_DATA = '0;
        bus.SIF_RD_VALID = 1'b0;
        repeat (3) tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        chk("rst_arready_up", 64'(bus.ARREADY), 64'd1);

        foreach (tab[i]) run_burst(tab[i]);

        // reset while waiting on the CGRA
        bus.ARID = 4'h9;
        bus.ARADDR = 32'h300;
        bus.ARLEN = 8'd3;
        bus.ARSIZE = 3'd3;
        bus.ARBURST = 2'b01;
        bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.ARVALID = 1'b0;
        chk("mid_sif_en", 64'(bus.SIF_RD_EN), 64'd1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        bus.SIF_RD_VALID = 1'b1;
        bus.SIF_RD_DATA = 64'h0123_4567_89AB_CDEF;
        tick();
        rst_n = 1'b1;
        tick();
        bus.SIF_RD_VALID = 1'b0;
        chk("mid_late_rvalid", 64'(bus.RVALID), 64'd0);
        chk("mid_arready", 64'(bus.ARREADY), 64'd1);
        run_burst(tab[0]);

        for (int i = 0; i < 30; i++) begin
            r.id = 4'($urandom);
            r.size = ($urandom_range(0, 9) == 0) ?
                     3'($urandom_range(4, 7)) :
                     3'($urandom_range(0, 3));
            r.burst = 2'($urandom);
            if (r.burst == 2'b10) begin
                case ($urandom_range(0, 4))
                    0: r.len = 8'd1;
                    1: r.len = 8'd3;
                    2: r.len = 8'd7;
                    3: r.len = 8'd15;
                    default: r.len = 8'($urandom_range(0, 7));
                endcase
            end else begin
                r.len = 8'($urandom_range(0, 7));
            end
            r.addr = $urandom & ~((32'd1 << r.size) - 32'd1);
            r.delay = $urandom_range(1, TO + 2);
            r.stall = $urandom_range(0, 3);
            r.data = {$urandom, $urandom};
            r.en = (r.size > 3'd3) ? 0 : int'(r.len) + 1;
            r.tab = 1'b0;
            r.ea = '0;
            run_burst(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aha_sif_read_bridge.md
Name: aha_sif_read_bridge

Overview:
- AXI4 read-only slave that converts 64-bit AXI bursts into single-beat simple-interface (SIF) read requests.
- Drives the CGRA packet read port: SIF_RD_ADDR, SIF_RD_EN, SIF_RD_DATA, SIF_RD_VALID.
- Sits between the SoC data interconnect and the Garnet processor packet read port, in the CGRA data path.
- One burst outstanding and one beat in flight at a time; a timeout guards against a CGRA that never answers.

Parameters:
- ID_WIDTH, 4, width of ARID/RID.
- TIMEOUT, 256, cycles to wait for SIF_RD_VALID before returning SLVERR; must be >=2.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- ARID  in  ID_WIDTH  read ID.
- ARADDR  in  32  byte start address.
- ARLEN  in  8  beats-1.
- ARSIZE  in  3  bytes per beat = 1<<ARSIZE.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
- ARLOCK/ARCACHE/ARPROT  in  1/4/3  ignored.
- ARVALID  in  1;  ARREADY  out  1.
- RID  out  ID_WIDTH;  RDATA  out  64;  RRESP  out  2;  RLAST  out  1;  RVALID  out  1;  RREADY  in  1.
- SIF_RD_ADDR  out  32  beat byte address, bits[2:0] forced 0.
- SIF_RD_EN  out  1  one-cycle read strobe.
- SIF_RD_DATA  in  64  read data.
- SIF_RD_VALID  in  1  data-valid strobe.

Behaviour:
- Clocking/reset: single clock ACLK. ARESETn is asynchronous, active-low.
- Reset values: state=IDLE, ARREADY=0 during reset and 1 from the first IDLE cycle. RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, SIF_RD_EN=0, SIF_RD_ADDR=0. Beat counter and timer=0.
- Reset mid-burst: immediately returns to IDLE and abandons the burst. No R beat is produced, and a late SIF_RD_VALID is ignored.
- IDLE:
  - ARREADY=1.
  - On ARVALID, capture id, addr, len, size, burst; beat count=0.
  - If ARSIZE>3, set err_all and go to RESP directly, with RDATA=0 and RRESP=SLVERR for every beat, without issuing any SIF read.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - SIF_RD_EN=1 and SIF_RD_ADDR=cur_addr&~7.
  - Timer cleared, then go to WAIT.
  - ARREADY=0 in every state other than IDLE.
- WAIT:
  - Timer increments each cycle.
  - SIF_RD_VALID=1: register RDATA=SIF_RD_DATA and RRESP=00, then go to RESP.
  - Else, if timer==TIMEOUT-1: RDATA=0, RRESP=10 (SLVERR), then go to RESP.
  - A valid arriving in the same cycle as the timeout wins (OKAY).
- RESP:
  - RVALID=1, RID=captured id, RLAST=(beat==len). RDATA and RRESP are held stable while RREADY=0.
  - On RREADY, if the beat was last, go to IDLE with RVALID=0 on the next cycle.
  - Otherwise advance the address, beat+1, then go to ISSUE (or stay in RESP with fresh SLVERR if err_all).
  - SIF_RD_VALID arriving in RESP or IDLE is ignored.
- Address advance:
  - FIXED: unchanged.
  - INCR: addr + (1<<size), 32-bit wrap-around at 2^32.
  - WRAP: boundary = (len+1)<<size, aligned base = addr & ~(boundary-1). When the next address reaches base+boundary, it returns to base.
  - WRAP with len not in {1,3,7,15} and burst=11 (reserved) are treated as INCR.
- Latency: AR handshake at cycle T, SIF_RD_EN at T+1. If SIF_RD_VALID is at T+1+k, RVALID is asserted at T+2+k. Zero-wait-state RREADY gives 3+k cycles per beat.
- Back-to-back bursts: new ARREADY is asserted the cycle after the last R handshake.

Test Plan:
- Single beat: ARADDR=0x100, ARLEN=0, ARSIZE=3, INCR. SIF_RD_EN one cycle with addr 0x100; SIF_RD_VALID 2 cycles later with 0xDEADBEEF_CAFEF00D → one R beat with that data, RRESP=00, RLAST=1, RID=ARID.
- INCR burst: ARADDR=0x0, ARLEN=3, size 3, RREADY always 1 → SIF addrs 0x0, 0x8, 0x10, 0x18; 4 R beats; RLAST only on the 4th.
- WRAP burst: ARADDR=0x18, ARLEN=3, size 3 → SIF addrs 0x18, 0x0, 0x8, 0x10.
- R backpressure: RREADY=0 for 5 cycles on beat 1 of an INCR len=1 burst → RDATA/RRESP stable; no second SIF_RD_EN until the handshake.
- Timeout: SIF_RD_VALID never asserted, TIMEOUT=8 → RVALID at SIF_RD_EN+9 with RRESP=10, RDATA=0; a late valid is ignored and the next burst completes OKAY.
- Reset and errors:
  - Assert ARESETn low while in WAIT → all outputs return to reset values at once; a subsequent burst completes normally.
  - ARSIZE=4 with len=1 → two SLVERR beats and zero SIF_RD_EN pulses.
